// File: rtl/im_loader_pkg.sv
// Shared types and MIPS field constants for the instruction-memory loader.
package im_loader_pkg;

    typedef enum logic [3:0] {
        MN_NOP  = 4'd0,
        MN_ADDU = 4'd1,
        MN_SUBU = 4'd2,
        MN_ORI  = 4'd3,
        MN_LW   = 4'd4,
        MN_SW   = 4'd5,
        MN_BEQ  = 4'd6,
        MN_LUI  = 4'd7,
        MN_JAL  = 4'd8,
        MN_JR   = 4'd9
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_WR,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/im_loader_if.sv
// Command handshake from the boot source and the write port into instruction memory.
interface im_loader_if #(
    parameter int ADDR_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_mnem;
    logic [4:0]        cmd_rs;
    logic [4:0]        cmd_rt;
    logic [4:0]        cmd_rd;
    logic [15:0]       cmd_imm;
    logic [25:0]       cmd_target;
    logic              cmd_last;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output cmd_valid, cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, cmd_last,
        input  cmd_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  cmd_valid, cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, cmd_last,
        output cmd_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/im_loader_instr_encoder.sv
// Mnemonic plus operand fields to a 32-bit MIPS word; the inverse of the core's decoder.
module instr_encoder
    import im_loader_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_NOP:  word = '0;
            MN_ADDU: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_ADDU};
            MN_SUBU: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SUBU};
            MN_JR:   word = {OP_RTYPE, rs, 15'b0, FN_JR};
            MN_ORI:  word = {OP_ORI, rs, rt, imm};
            MN_LW:   word = {OP_LW, rs, rt, imm};
            MN_SW:   word = {OP_SW, rs, rt, imm};
            MN_BEQ:  word = {OP_BEQ, rs, rt, imm};
            MN_LUI:  word = {OP_LUI, 5'b0, rt, imm};
            MN_JAL:  word = {OP_JAL, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory writer; holds the CPU in reset until the program is loaded.
//   state  | meaning
//   S_IDLE | waiting for a command (cmd_ready high)
//   S_ENC  | encoding the latched command into im_wdata
//   S_WR   | one-cycle write strobe, then advance address/count
//   S_DONE | load finished (last seen or memory full), sticky
//   S_ERR  | illegal mnemonic received, sticky
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    im_loader_if.slave    bus,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          full,
    output logic          err,
    output logic [ADDR_W:0] count
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_e state, stateNext;

    logic [3:0]        mnemQ;
    logic [4:0]        rsQ, rtQ, rdQ;
    logic [15:0]       immQ;
    logic [25:0]       targetQ;
    logic              lastQ;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wdataQ;

    logic [3:0]        encMnem;
    logic [4:0]        encRs, encRt, encRd;
    logic [15:0]       encImm;
    logic [25:0]       encTarget;
    logic [31:0]       encWord;
    logic              encIllegal;
    logic [ADDR_W:0]   countInc;
    logic              fillNext;

    // One encoder serves both jobs: legality of the incoming command in IDLE,
    // and the word for the latched command afterwards.
    always_comb begin
        encMnem   = mnemQ;
        encRs     = rsQ;
        encRt     = rtQ;
        encRd     = rdQ;
        encImm    = immQ;
        encTarget = targetQ;
        if (state == S_IDLE) begin
            encMnem   = bus.cmd_mnem;
            encRs     = bus.cmd_rs;
            encRt     = bus.cmd_rt;
            encRd     = bus.cmd_rd;
            encImm    = bus.cmd_imm;
            encTarget = bus.cmd_target;
        end
    end

    instr_encoder u_encoder (
        .mnem    (encMnem),
        .rs      (encRs),
        .rt      (encRt),
        .rd      (encRd),
        .imm     (encImm),
        .target  (encTarget),
        .word    (encWord),
        .illegal (encIllegal)
    );

    assign countInc      = count + 1'b1;
    assign fillNext      = (countInc == DEPTH_W);
    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.im_we     = (state == S_WR) && !restart;
    assign bus.im_addr   = addrQ;
    assign bus.im_wdata  = wdataQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (restart) begin
            stateNext = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.cmd_valid) stateNext = encIllegal ? S_ERR : S_ENC;
                S_ENC:   stateNext = S_WR;
                S_WR:    stateNext = (lastQ || fillNext) ? S_DONE : S_IDLE;
                default: stateNext = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mnemQ     <= '0;
            rsQ       <= '0;
            rtQ       <= '0;
            rdQ       <= '0;
            immQ      <= '0;
            targetQ   <= '0;
            lastQ     <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            count     <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else if (restart) begin
            addrQ     <= '0;
            count     <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (encIllegal) begin
                            err <= 1'b1;
                        end else begin
                            mnemQ   <= bus.cmd_mnem;
                            rsQ     <= bus.cmd_rs;
                            rtQ     <= bus.cmd_rt;
                            rdQ     <= bus.cmd_rd;
                            immQ    <= bus.cmd_imm;
                            targetQ <= bus.cmd_target;
                            lastQ   <= bus.cmd_last;
                        end
                    end
                end
                S_ENC: wdataQ <= encWord;
                S_WR: begin
                    addrQ <= addrQ + 1'b1;
                    count <= countInc;
                    if (lastQ || fillNext) begin
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end
                    if (!lastQ && fillNext) full <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: scoreboard of expected memory writes plus point checks.
module tb_im_loader;
    import im_loader_pkg::*;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        restartL, restartS;
    logic        cpuHoldL, loadDoneL, fullL, errL;
    logic [10:0] countL;
    logic        cpuHoldS, loadDoneS, fullS, errS;
    logic [2:0]  countS;

    int  checks = 0;
    int  errors = 0;
    wr_t qL[$];
    wr_t qS[$];

    im_loader_if #(.ADDR_W(10)) busL ();
    im_loader_if #(.ADDR_W(2))  busS ();

    im_loader #(.ADDR_W(10), .DEPTH(1024)) dutL (
        .clk(clk), .reset(reset), .restart(restartL), .bus(busL),
        .cpu_hold(cpuHoldL), .load_done(loadDoneL), .full(fullL), .err(errL), .count(countL)
    );

    im_loader #(.ADDR_W(2), .DEPTH(4)) dutS (
        .clk(clk), .reset(reset), .restart(restartS), .bus(busS),
        .cpu_hold(cpuHoldS), .load_done(loadDoneS), .full(fullS), .err(errS), .count(countS)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sm, input logic v, input logic [3:0] mn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input logic [25:0] tg, input logic last);
        if (sm) begin
            busS.cmd_valid = v; busS.cmd_mnem = mn; busS.cmd_rs = rs; busS.cmd_rt = rt;
            busS.cmd_rd = rd; busS.cmd_imm = imm; busS.cmd_target = tg; busS.cmd_last = last;
        end else begin
            busL.cmd_valid = v; busL.cmd_mnem = mn; busL.cmd_rs = rs; busL.cmd_rt = rt;
            busL.cmd_rd = rd; busL.cmd_imm = imm; busL.cmd_target = tg; busL.cmd_last = last;
        end
    endtask

    task automatic expectWr(input bit sm, input logic [9:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        if (sm) qS.push_back(e);
        else    qL.push_back(e);
    endtask

    // Waits (bounded) for cmd_ready, then presents the command for exactly one cycle.
    task automatic sendCmd(input bit sm, input logic [3:0] mn,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [15:0] imm, input logic [25:0] tg, input logic last);
        int n = 0;
        while (!(sm ? busS.cmd_ready : busL.cmd_ready) && n < 16) begin
            tick(1);
            n++;
        end
        check("ready_wait", (sm ? busS.cmd_ready : busL.cmd_ready), 1'b1);
        drive(sm, 1'b1, mn, rs, rt, rd, imm, tg, last);
        tick(1);
        drive(sm, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (busL.im_we === 1'b1) begin
            if (qL.size() == 0) check("sbL_unexpected_we", busL.im_we, 1'b0);
            else begin
                e = qL.pop_front();
                check("sbL_addr", busL.im_addr, e.addr);
                check("sbL_data", busL.im_wdata, e.data);
            end
        end
        if (busS.im_we === 1'b1) begin
            if (qS.size() == 0) check("sbS_unexpected_we", busS.im_we, 1'b0);
            else begin
                e = qS.pop_front();
                check("sbS_addr", busS.im_addr, e.addr);
                check("sbS_data", busS.im_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        restartL = 1'b0;
        restartS = 1'b0;
        drive(0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        drive(1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        #12;
        check("rst_ready", busL.cmd_ready, 1'b1);
        check("rst_we", busL.im_we, 1'b0);
        check("rst_addr", busL.im_addr, 10'd0);
        check("rst_wdata", busL.im_wdata, 32'd0);
        check("rst_hold", cpuHoldL, 1'b1);
        check("rst_done", loadDoneL, 1'b0);
        check("rst_full", fullL, 1'b0);
        check("rst_err", errL, 1'b0);
        check("rst_count", countL, 11'd0);
        check("rstS_ready", busS.cmd_ready, 1'b1);
        check("rstS_hold", cpuHoldS, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        tick(1);

        // ADDU: strobe two cycles after the handshake, for one cycle only
        expectWr(0, 10'd0, 32'h00221821);
        drive(0, 1'b1, MN_ADDU, 5'd1, 5'd2, 5'd3, 16'h5555, 26'h3FFFFFF, 1'b0);
        tick(1);
        drive(0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        check("addu_enc_we", busL.im_we, 1'b0);
        check("addu_enc_ready", busL.cmd_ready, 1'b0);
        tick(1);
        check("addu_wr_we", busL.im_we, 1'b1);
        check("addu_wr_addr", busL.im_addr, 10'd0);
        check("addu_wr_data", busL.im_wdata, 32'h00221821);
        tick(1);
        check("addu_post_we", busL.im_we, 1'b0);
        check("addu_count", countL, 11'd1);
        check("addu_next_addr", busL.im_addr, 10'd1);

        expectWr(0, 10'd1, 32'h00853023);
        sendCmd(0, MN_SUBU, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'd0, 1'b0);
        expectWr(0, 10'd2, 32'h00000000);
        sendCmd(0, MN_NOP, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        tick(2);
        check("three_count", countL, 11'd3);
        check("three_hold", cpuHoldL, 1'b1);

        restartL = 1'b1;
        tick(1);
        restartL = 1'b0;
        check("restart_addr", busL.im_addr, 10'd0);
        check("restart_count", countL, 11'd0);

        // Program sequence ending with last
        expectWr(0, 10'd0, 32'h34011234);
        sendCmd(0, MN_ORI, 5'd0, 5'd1, 5'd0, 16'h1234, 26'd0, 1'b0);
        expectWr(0, 10'd1, 32'h8C020004);
        sendCmd(0, MN_LW, 5'd0, 5'd2, 5'd0, 16'h0004, 26'd0, 1'b0);
        expectWr(0, 10'd2, 32'hAC020008);
        sendCmd(0, MN_SW, 5'd0, 5'd2, 5'd0, 16'h0008, 26'd0, 1'b0);
        expectWr(0, 10'd3, 32'h1022FFFF);
        sendCmd(0, MN_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0);
        expectWr(0, 10'd4, 32'h3C05ABCD);
        sendCmd(0, MN_LUI, 5'd7, 5'd5, 5'd9, 16'hABCD, 26'd0, 1'b0);
        expectWr(0, 10'd5, 32'h0C000C00);
        sendCmd(0, MN_JAL, 5'd3, 5'd3, 5'd3, 16'h1111, 26'hC00, 1'b0);
        expectWr(0, 10'd6, 32'h03E00008);
        sendCmd(0, MN_JR, 5'd31, 5'd7, 5'd8, 16'h2222, 26'd0, 1'b1);
        tick(2);
        check("seq_done", loadDoneL, 1'b1);
        check("seq_hold", cpuHoldL, 1'b0);
        check("seq_ready", busL.cmd_ready, 1'b0);
        check("seq_count", countL, 11'd7);
        check("seq_full", fullL, 1'b0);

        drive(0, 1'b1, MN_ADDU, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        tick(4);
        drive(0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        check("done_sticky_count", countL, 11'd7);
        check("done_sticky_flag", loadDoneL, 1'b1);

        // Illegal mnemonics at both ends of the illegal range
        restartL = 1'b1;
        tick(1);
        restartL = 1'b0;
        check("rs2_done", loadDoneL, 1'b0);
        check("rs2_hold", cpuHoldL, 1'b1);
        sendCmd(0, 4'hA, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        check("illA_err", errL, 1'b1);
        check("illA_ready", busL.cmd_ready, 1'b0);
        tick(3);
        check("illA_we", busL.im_we, 1'b0);
        check("illA_sticky", errL, 1'b1);
        check("illA_count", countL, 11'd0);
        restartL = 1'b1;
        tick(1);
        restartL = 1'b0;
        check("illA_rs_err", errL, 1'b0);
        check("illA_rs_hold", cpuHoldL, 1'b1);
        check("illA_rs_ready", busL.cmd_ready, 1'b1);
        check("illA_rs_addr", busL.im_addr, 10'd0);
        sendCmd(0, 4'hF, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        check("illF_err", errL, 1'b1);
        restartL = 1'b1;
        tick(1);
        restartL = 1'b0;

        // restart beats a simultaneous handshake
        drive(0, 1'b1, MN_ADDU, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        restartL = 1'b1;
        tick(1);
        restartL = 1'b0;
        drive(0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        check("rsv_ready", busL.cmd_ready, 1'b1);
        tick(3);
        check("rsv_count", countL, 11'd0);
        check("rsv_we", busL.im_we, 1'b0);

        // restart during WR suppresses the strobe
        sendCmd(0, MN_ADDU, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        tick(1);
        check("rswr_we_before", busL.im_we, 1'b1);
        restartL = 1'b1;
        #1;
        check("rswr_we_after", busL.im_we, 1'b0);
        tick(1);
        restartL = 1'b0;
        check("rswr_count", countL, 11'd0);
        check("rswr_ready", busL.cmd_ready, 1'b1);

        // asynchronous reset in the middle of a write
        expectWr(0, 10'd0, 32'h00000000);
        sendCmd(0, MN_NOP, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        sendCmd(0, MN_ADDU, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        tick(1);
        check("arst_we_before", busL.im_we, 1'b1);
        check("arst_addr_before", busL.im_addr, 10'd1);
        reset = 1'b0;
        #1;
        check("arst_we", busL.im_we, 1'b0);
        check("arst_addr", busL.im_addr, 10'd0);
        check("arst_count", countL, 11'd0);
        check("arst_wdata", busL.im_wdata, 32'd0);
        check("arst_hold", cpuHoldL, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        check("arst_rel_ready", busL.cmd_ready, 1'b1);
        check("arst_rel_addr", busL.im_addr, 10'd0);

        // Small memory fills without last
        for (int i = 0; i < 4; i++) begin
            expectWr(1, 10'(i), 32'h00000000);
            sendCmd(1, MN_NOP, 5'(i + 1), 5'd7, 5'd9, 16'hBEEF, 26'h155, 1'b0);
        end
        tick(2);
        check("fill_full", fullS, 1'b1);
        check("fill_done", loadDoneS, 1'b1);
        check("fill_count", countS, 3'd4);
        check("fill_hold", cpuHoldS, 1'b0);
        check("fill_ready", busS.cmd_ready, 1'b0);
        check("fill_addr_wrap", busS.im_addr, 2'd0);
        drive(1, 1'b1, MN_ADDU, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        tick(5);
        drive(1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        check("fill_ignore_count", countS, 3'd4);
        check("fill_ignore_full", fullS, 1'b1);

        tick(2);
        check("sbL_drained", qL.size(), 0);
        check("sbS_drained", qS.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time instruction memory writer for the single-cycle MIPS core. It encodes the inverse of the instruction decoder.
- Accepts mnemonic-level commands over a valid/ready handshake and assembles each into a 32-bit MIPS word.
- Writes words to consecutive instruction-memory addresses.
- Holds the CPU in reset until loading is complete.

Parameters:
- ADDR_W, 10, word-address width of instruction memory.
- DEPTH, 1024, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- restart  input  1  synchronous request to begin a new load.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  loader can accept a command.
- cmd_mnem  input  4  mnemonic code, see package enum.
- cmd_rs  input  5  rs field.
- cmd_rt  input  5  rt field.
- cmd_rd  input  5  rd field.
- cmd_imm  input  16  immediate field.
- cmd_target  input  26  jal target field.
- cmd_last  input  1  this command is the final instruction.
- im_we  output  1  instruction-memory write strobe.
- im_addr  output  ADDR_W  word address of write.
- im_wdata  output  32  encoded instruction.
- cpu_hold  output  1  keeps the CPU in reset while high.
- load_done  output  1  load finished.
- full  output  1  memory filled without cmd_last.
- err  output  1  illegal mnemonic received.
- count  output  ADDR_W+1  words written in this load.

Behaviour:
- Reset values: state IDLE, cmd_ready 1, im_we 0, im_addr 0, im_wdata 0, cpu_hold 1, load_done 0, full 0, err 0, count 0.
- Reset is asynchronous: outputs take reset values immediately, including mid-write, and no partial write is issued.
- States: IDLE, ENC, WR, DONE, ERR. cmd_ready=1 only in IDLE.
- IDLE:
  - Handshake occurs when cmd_valid & cmd_ready.
  - A legal mnemonic latches all fields plus last, then moves to ENC.
  - An illegal mnemonic (10..15) sets err and moves to ERR; nothing is written.
- ENC: im_wdata <= encoded word, then moves to WR.
- WR:
  - im_we=1 for exactly one cycle at im_addr.
  - Next cycle: im_addr+1 with wrap to 0 after DEPTH-1, and count+1.
  - If last: load_done=1, cpu_hold=0, go to DONE.
  - Else if count+1==DEPTH: full=1, load_done=1, cpu_hold=0, go to DONE.
  - Else go to IDLE.
- Latency: the write strobe is asserted 2 cycles after the handshake cycle. Throughput is 1 command per 3 cycles.
- DONE and ERR are sticky. cmd_valid is ignored there.
- restart, from any state:
  - Next cycle: IDLE, im_addr 0, count 0, flags cleared, cpu_hold 1.
  - It beats a simultaneous handshake: that command is not accepted.
  - In WR it suppresses the pending im_we.
- Encodings (op, func in hex):
  - NOP: 32'h0.
  - ADDU: {00, rs, rt, rd, 00000, 21}.
  - SUBU: {00, rs, rt, rd, 00000, 23}.
  - JR: {00, rs, 15'b0, 08}.
  - ORI: {0D, rs, rt, imm}.
  - LW: {23, rs, rt, imm}.
  - SW: {2B, rs, rt, imm}.
  - BEQ: {04, rs, rt, imm}.
  - LUI: {0F, 5'b0, rt, imm}.
  - JAL: {03, target}.
  - Fields not used by a mnemonic are ignored.

Decomposition:
- Package im_loader_pkg holds:
  - mnemonic enum: NOP 0, ADDU 1, SUBU 2, ORI 3, LW 4, SW 5, BEQ 6, LUI 7, JAL 8, JR 9.
  - opcode constants 00/0D/23/2B/04/0F/03.
  - func constants 21/23/08.
  - state enum.
- One combinational sub-module, instr_encoder: mnem and fields in, word and illegal flag out. It is reused by the assembler-side bench model.

Test Plan:
- ADDU rs=1 rt=2 rd=3 -> im_wdata 0x00221821 at im_addr 0, im_we high one cycle, 2 cycles after handshake; count 1.
- Sequence ORI rt=1 imm=0x1234; LW rt=2 imm=4; SW rt=2 imm=8; BEQ rs=1 rt=2 imm=0xFFFF; LUI rt=5 imm=0xABCD; JAL target=0xC00; JR rs=31 with last -> 0x34011234, 0x8C020004, 0xAC020008, 0x1022FFFF, 0x3C05ABCD, 0x0C000C00, 0x03E00008 at addresses 0..6; then load_done 1, cpu_hold 0, cmd_ready 0.
- cmd_mnem=0xA -> err 1, no im_we, cmd_ready 0; restart -> err 0, cpu_hold 1, cmd_ready 1 next cycle, im_addr 0.
- ADDR_W=2: four NOPs without last -> writes at addresses 0..3, then full 1, load_done 1, count 4, further cmd_valid ignored.
- reset low during WR -> im_we 0 immediately; after release im_addr 0, count 0, cpu_hold 1.
- restart and cmd_valid in the same IDLE cycle -> command not accepted; no write follows.
